// File: rtl/adder_serial_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_serial_driver_if
// Operand/result handshakes and bit-serial adder link for adder_serial_driver.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface adder_serial_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_clr;
  logic             ser_a;
  logic             ser_b;
  logic             ser_o;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;

  modport master (
    input  in_valid, in_a, in_b, ser_o, out_ready,
    output in_ready, ser_clr, ser_a, ser_b, out_valid, out_sum
  );

  modport slave (
    output in_valid, in_a, in_b, ser_o, out_ready,
    input  in_ready, ser_clr, ser_a, ser_b, out_valid, out_sum
  );
endinterface
`default_nettype wire

// File: rtl/adder_serial_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_serial_driver
// Shifts two parallel operands LSB-first into a bit-serial adder and
// reassembles the (WIDTH+1)-bit sum, carry-out included.
// Revision: 1.0
// ---------------------------------------------------------------------------
module adder_serial_driver #(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  adder_serial_driver_if.master bus
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] c_last = CW'(WIDTH);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_state;
  logic [WIDTH:0] r_sha;
  logic [WIDTH:0] r_shb;
  logic [WIDTH:0] r_sum;
  logic [CW-1:0]  r_tx;
  logic [CW-1:0]  r_rx;
  logic           r_ser_a;
  logic           r_ser_b;
  logic           r_out_valid;
  logic           w_cap;

  assign bus.in_ready  = (r_state == S_IDLE) && !RST;
  assign bus.ser_clr   = (r_state == S_CLR) || RST;
  assign bus.ser_a     = r_ser_a;
  assign bus.ser_b     = r_ser_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;

  // w_cap marks the cycle in which SER_O carries the sum of a bit pair
  // driven ADD_LAT cycles earlier.
  generate
    if (ADD_LAT == 0) begin : g_lat0
      assign w_cap = (r_state == S_SHIFT);
    end else begin : g_latn
      logic [ADD_LAT-1:0] r_vp;
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_vp <= '0;
        end else begin
          r_vp[0] <= (r_state == S_SHIFT);
          for (int i = 1; i < ADD_LAT; i++) begin
            r_vp[i] <= r_vp[i-1];
          end
        end
      end
      assign w_cap = r_vp[ADD_LAT-1];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_sha       <= '0;
      r_shb       <= '0;
      r_sum       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_ser_a     <= 1'b0;
      r_ser_b     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_cap) begin
        r_sum <= {bus.ser_o, r_sum[WIDTH:1]};
        r_rx  <= r_rx + c_one;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sha   <= {1'b0, bus.in_a};
            r_shb   <= {1'b0, bus.in_b};
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_ser_a <= r_sha[0];
          r_ser_b <= r_shb[0];
          r_sha   <= r_sha >> 1;
          r_shb   <= r_shb >> 1;
          r_tx    <= '0;
          r_rx    <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_tx == c_last) begin
            r_ser_a <= 1'b0;
            r_ser_b <= 1'b0;
            if (ADD_LAT == 0) begin
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_ser_a <= r_sha[0];
            r_ser_b <= r_shb[0];
            r_sha   <= r_sha >> 1;
            r_shb   <= r_shb >> 1;
            r_tx    <= r_tx + c_one;
          end
        end
        S_DRAIN: begin
          if (w_cap && (r_rx == c_last)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_adder_serial_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adder_serial_driver
// Directed bench with behavioural serial adders for ADD_LAT=0 and ADD_LAT=1.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_adder_serial_driver;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  adder_serial_driver_if #(.WIDTH(8)) b0 ();
  adder_serial_driver_if #(.WIDTH(8)) b1 ();

  adder_serial_driver #(.WIDTH(8), .ADD_LAT(0)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
  adder_serial_driver #(.WIDTH(8), .ADD_LAT(1)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));

  // Serial adders: combinational sum for dut0, registered sum for dut1.
  logic c0 = 1'b0;
  logic c1 = 1'b0;
  logic o1 = 1'b0;
  assign b0.ser_o = b0.ser_a ^ b0.ser_b ^ c0;
  assign b1.ser_o = o1;
  always @(posedge CLK) begin
    if (b0.ser_clr) c0 <= 1'b0;
    else c0 <= (b0.ser_a & b0.ser_b) | (c0 & (b0.ser_a ^ b0.ser_b));
    if (b1.ser_clr) begin
      c1 <= 1'b0;
      o1 <= 1'b0;
    end else begin
      o1 <= b1.ser_a ^ b1.ser_b ^ c1;
      c1 <= (b1.ser_a & b1.ser_b) | (c1 & (b1.ser_a ^ b1.ser_b));
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Run one operation on dut0; lat is the cycle index of first OUT_VALID.
  task automatic op0(input logic [7:0] a, input logic [7:0] b,
                     output logic [8:0] sum, output int lat);
    int n;
    n = 0;
    b0.in_a = a;
    b0.in_b = b;
    b0.in_valid = 1'b1;
    while (!b0.in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) check("op0_accept_timeout", 32'd0, 32'd1);
    @(negedge CLK);
    b0.in_valid = 1'b0;
    lat = 1;
    while (!b0.out_valid && lat < 60) begin
      @(negedge CLK);
      lat++;
    end
    if (lat >= 60) check("op0_result_timeout", 32'd0, 32'd1);
    sum = b0.out_sum;
    b0.out_ready = 1'b1;
    @(negedge CLK);
    b0.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [8:0] sum;
    logic [8:0] sa;
    logic [8:0] sb;
    logic [8:0] held;
    int lat;
    int seen;

    tbl[0] = '{8'h03, 8'h05, 9'h008};
    tbl[1] = '{8'hFF, 8'h01, 9'h100};
    tbl[2] = '{8'hFF, 8'hFF, 9'h1FE};
    tbl[3] = '{8'h01, 8'h01, 9'h002};
    tbl[4] = '{8'h0A, 8'h14, 9'h01E};
    tbl[5] = '{8'h80, 8'h80, 9'h100};
    tbl[6] = '{8'h00, 8'h00, 9'h000};
    tbl[7] = '{8'h5A, 8'hA5, 9'h0FF};
    tbl[8] = '{8'h7F, 8'h01, 9'h080};

    b0.in_valid = 1'b0; b0.in_a = '0; b0.in_b = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.out_ready = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst_in_ready", 32'(b0.in_ready), 32'd0);
    check("rst_ser_clr", 32'(b0.ser_clr), 32'd1);
    check("rst_out_valid", 32'(b0.out_valid), 32'd0);
    check("rst_out_sum", 32'(b0.out_sum), 32'd0);
    check("rst_ser_ab", 32'({b0.ser_a, b0.ser_b}), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_in_ready", 32'(b0.in_ready), 32'd1);
    check("idle_ser_clr", 32'(b0.ser_clr), 32'd0);

    // Cycle-accurate trace of 0x03 + 0x05.
    b0.in_a = 8'h03; b0.in_b = 8'h05; b0.in_valid = 1'b1;
    @(negedge CLK);
    b0.in_valid = 1'b0;
    b0.in_a = 8'hEE; b0.in_b = 8'hEE;
    check("t1_clr_cycle1", 32'(b0.ser_clr), 32'd1);
    check("t1_ser_ab_cycle1", 32'({b0.ser_a, b0.ser_b}), 32'd0);
    check("t1_in_ready_cycle1", 32'(b0.in_ready), 32'd0);
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      sa[k] = b0.ser_a;
      sb[k] = b0.ser_b;
    end
    check("t1_ser_a_bits", 32'(sa), 32'h003);
    check("t1_ser_b_bits", 32'(sb), 32'h005);
    check("t1_out_valid_cycle10", 32'(b0.out_valid), 32'd0);
    @(negedge CLK);
    check("t1_out_valid_cycle11", 32'(b0.out_valid), 32'd1);
    check("t1_out_sum", 32'(b0.out_sum), 32'h008);
    b0.out_ready = 1'b1;
    @(negedge CLK);
    b0.out_ready = 1'b0;

    for (int i = 0; i < 9; i++) begin
      op0(tbl[i].a, tbl[i].b, sum, lat);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(tbl[i].s));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd11);
      check($sformatf("vec%0d_ready_after", i), 32'(b0.in_ready), 32'd1);
    end

    // Result held while downstream stalls; new operand must not be taken.
    b0.in_a = 8'h12; b0.in_b = 8'h34; b0.in_valid = 1'b1;
    @(negedge CLK);
    b0.in_valid = 1'b0;
    lat = 1;
    while (!b0.out_valid && lat < 60) begin
      @(negedge CLK);
      lat++;
    end
    check("t4_first_valid", 32'(lat), 32'd11);
    held = b0.out_sum;
    check("t4_sum", 32'(held), 32'h046);
    b0.in_a = 8'h10; b0.in_b = 8'h00; b0.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("t4_stall_valid", 32'(b0.out_valid), 32'd1);
      check("t4_stall_sum", 32'(b0.out_sum), 32'(held));
      check("t4_stall_in_ready", 32'(b0.in_ready), 32'd0);
    end
    b0.out_ready = 1'b1;
    @(negedge CLK);
    b0.out_ready = 1'b0;
    b0.in_valid = 1'b0;
    check("t4_valid_dropped", 32'(b0.out_valid), 32'd0);
    check("t4_in_ready_back", 32'(b0.in_ready), 32'd1);
    @(negedge CLK);
    check("t4_no_queued_op", 32'({b0.ser_clr, b0.in_ready}), 32'd1);

    // Reset in cycle 5 of an operation aborts it.
    b0.in_a = 8'h77; b0.in_b = 8'h11; b0.in_valid = 1'b1;
    @(negedge CLK);
    b0.in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("t5_rst_ser_clr", 32'(b0.ser_clr), 32'd1);
    check("t5_rst_in_ready", 32'(b0.in_ready), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("t5_idle_after_rst", 32'(b0.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (b0.out_valid) seen++;
    end
    check("t5_no_out_valid", 32'(seen), 32'd0);
    op0(8'h0A, 8'h14, sum, lat);
    check("t5_sum_after_rst", 32'(sum), 32'h01E);

    // ADD_LAT=1 against a registered-sum adder.
    for (int i = 0; i < 2; i++) begin
      b1.in_a = (i == 0) ? 8'hAA : 8'hFF;
      b1.in_b = (i == 0) ? 8'h55 : 8'h01;
      b1.in_valid = 1'b1;
      check("t6_in_ready", 32'(b1.in_ready), 32'd1);
      @(negedge CLK);
      b1.in_valid = 1'b0;
      lat = 1;
      while (!b1.out_valid && lat < 60) begin
        @(negedge CLK);
        lat++;
      end
      check("t6_lat", 32'(lat), 32'd12);
      check("t6_sum", 32'(b1.out_sum), (i == 0) ? 32'h0FF : 32'h100);
      b1.out_ready = 1'b1;
      @(negedge CLK);
      b1.out_ready = 1'b0;
      check("t6_valid_dropped", 32'(b1.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
